// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the EX-stage ALU, ALU control decode and the
// multi-cycle multiply sequencer: ALU control codes and sequencer state
// encodings.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  // 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_mul_step.sv
// One shift-add multiply step: adds mcand * mplier_slice_i to the
// accumulator, modulo 2^WIDTH.
//   acc_i          running partial product
//   mcand_i        multiplicand, already shifted to the current weight
//   mplier_slice_i BPC low bits of the remaining multiplier
//   acc_o          updated partial product
module alu_mul_sequencer_mul_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [BPC-1:0]   mplier_slice_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_slice_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative multiply sequencer beside the EX-stage ALU. Accepts a MUL from
// EX, stalls the pipeline for N+1 cycles while retiring BITS_PER_CYCLE
// multiplier bits per cycle, then presents the low WIDTH product bits with
// a one-cycle done_o pulse.
//
//   state | meaning
//   IDLE  | waiting for a MUL; stall_o follows start combinationally
//   RUN   | shift-add iterations, count 0..N-1; flush aborts to IDLE
//   DONE  | result_o valid, done_o high; inputs ignored
//
// Ports:
//   clk_i, rst_i (async, active low)
//   valid_i, ALUCtrl_i, data1_i, data2_i, flush_i  from the EX stage
//   stall_o   hold PC/IF/ID/EX
//   busy_o    state != IDLE
//   done_o    result_o valid this cycle
//   result_o  product[WIDTH-1:0], held until the next completion
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             start;
  logic [WIDTH-1:0] acc_step;

  assign start = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i;

  alu_mul_sequencer_mul_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_mul_step (
    .acc_i          (acc_q),
    .mcand_i        (mcand_q),
    .mplier_slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o          (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        stall_o = start;
        if (start) begin
          mcand_d  = data1_i;
          mplier_d = data2_i;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          count_d  = count_q + 1'b1;
          // Fixed latency: always N steps, even once the multiplier is exhausted
          if (count_q == CNT_LAST) begin
            result_d = acc_step;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The MUL is still sitting in EX; ignoring inputs here prevents a retrigger
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one instance at BITS_PER_CYCLE=1
// (N=32) and one at BITS_PER_CYCLE=4 (N=8), each with its own valid_i.
module tb_alu_mul_sequencer;

  localparam logic [2:0] C_AND = 3'b001;
  localparam logic [2:0] C_OR  = 3'b010;
  localparam logic [2:0] C_ADD = 3'b011;
  localparam logic [2:0] C_SUB = 3'b100;
  localparam logic [2:0] C_MUL = 3'b101;

  logic        clk_sys;
  logic        rst_n;
  logic        valid_a, valid_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] d1, d2;
  logic        flush;
  logic        stall_a, busy_a, done_a;
  logic        stall_b, busy_b, done_b;
  logic [31:0] result_a, result_b;

  int n_checks = 0;
  int n_fail   = 0;

  int          ndone, cyc1, cyc2, seen;
  logic [31:0] r1, r2;

  alu_mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut_bpc1 (
    .clk_i     (clk_sys),
    .rst_i     (rst_n),
    .valid_i   (valid_a),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (d1),
    .data2_i   (d2),
    .flush_i   (flush),
    .stall_o   (stall_a),
    .busy_o    (busy_a),
    .done_o    (done_a),
    .result_o  (result_a)
  );

  alu_mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut_bpc4 (
    .clk_i     (clk_sys),
    .rst_i     (rst_n),
    .valid_i   (valid_b),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (d1),
    .data2_i   (d2),
    .flush_i   (flush),
    .stall_o   (stall_b),
    .busy_o    (busy_b),
    .done_o    (done_b),
    .result_o  (result_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_stall(input int sel);
    return (sel == 0) ? stall_a : stall_b;
  endfunction

  function automatic logic o_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  function automatic logic [31:0] o_result(input int sel);
    return (sel == 0) ? result_a : result_b;
  endfunction

  // Issue one MUL on the selected instance; expects done in cycle n+1,
  // stall high for n+1 cycles and exactly one done pulse.
  task automatic do_mul(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int n, input string tag);
    int stall_cnt = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    @(negedge clk_sys);
    alu_ctrl = C_MUL;
    d1 = a;
    d2 = b;
    if (sel == 0) valid_a = 1'b1;
    else          valid_b = 1'b1;
    for (int c = 0; c < n + 5; c++) begin
      #1;
      if (o_stall(sel)) stall_cnt++;
      if (o_done(sel)) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c;
          check_val({tag, "_result"}, o_result(sel), exp_res);
          check_val({tag, "_stall_at_done"}, 32'(o_stall(sel)), 32'd0);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
      end
      @(negedge clk_sys);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    check_val({tag, "_done_cycle"}, 32'(done_cyc), 32'(n + 1));
    check_val({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(n + 1));
    check_val({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_a  = 1'b0;
    valid_b  = 1'b0;
    alu_ctrl = 3'b000;
    d1       = '0;
    d2       = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    check_val("rst_stall", 32'(stall_a | stall_b), 32'd0);
    check_val("rst_busy", 32'(busy_a | busy_b), 32'd0);
    check_val("rst_done", 32'(done_a | done_b), 32'd0);
    check_val("rst_result_a", result_a, 32'd0);
    check_val("rst_result_b", result_b, 32'd0);
    rst_n = 1'b1;

    do_mul(0, 32'd7, 32'd6, 32'd42, 32, "mul7x6_bpc1");

    // Reset asserted in the middle of RUN
    @(negedge clk_sys);
    alu_ctrl = C_MUL; d1 = 32'd9; d2 = 32'd9; valid_a = 1'b1;
    repeat (6) @(negedge clk_sys);
    valid_a = 1'b0;
    #1;
    check_val("midrun_busy_before_rst", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrun_rst_busy", 32'(busy_a), 32'd0);
    check_val("midrun_rst_stall", 32'(stall_a), 32'd0);
    check_val("midrun_rst_done", 32'(done_a), 32'd0);
    check_val("midrun_rst_result", result_a, 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "mulmax_bpc1");
    do_mul(0, 32'h8000_0000, 32'd2, 32'd0, 32, "mulwrap_bpc1");
    do_mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 8, "mulmax_bpc4");
    do_mul(1, 32'h8000_0000, 32'd2, 32'd0, 8, "mulwrap_bpc4");
    do_mul(1, 32'd7, 32'd6, 32'd42, 8, "mul7x6_bpc4");
    do_mul(1, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 8, "mulshift_bpc4");

    // Non-MUL codes never engage the sequencer
    foreach (r1[i]) begin end
    for (int k = 0; k < 4; k++) begin
      logic [2:0] codes [4];
      codes[0] = C_AND; codes[1] = C_OR; codes[2] = C_ADD; codes[3] = C_SUB;
      @(negedge clk_sys);
      alu_ctrl = codes[k];
      d1 = 32'd3; d2 = 32'd4;
      valid_a = 1'b1; valid_b = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (stall_a | busy_a | done_a | stall_b | busy_b | done_b) seen++;
        @(negedge clk_sys);
      end
      check_val($sformatf("nonmul_code%0d_activity", codes[k]), 32'(seen), 32'd0);
      valid_a = 1'b0; valid_b = 1'b0;
    end

    // flush_i in IDLE blocks start
    @(negedge clk_sys);
    alu_ctrl = C_MUL; d1 = 32'd2; d2 = 32'd2; valid_a = 1'b1; flush = 1'b1;
    #1;
    check_val("idle_flush_stall", 32'(stall_a), 32'd0);
    @(negedge clk_sys);
    #1;
    check_val("idle_flush_busy", 32'(busy_a), 32'd0);
    valid_a = 1'b0; flush = 1'b0;

    do_mul(0, 32'd11, 32'd13, 32'd143, 32, "mul11x13_bpc1");

    // Flush at RUN cycle 10
    @(negedge clk_sys);
    alu_ctrl = C_MUL; d1 = 32'd100; d2 = 32'd100; valid_a = 1'b1;
    repeat (10) @(negedge clk_sys);
    flush = 1'b1; valid_a = 1'b0;
    #1;
    check_val("flush_busy_in_run", 32'(busy_a), 32'd1);
    @(negedge clk_sys);
    flush = 1'b0;
    #1;
    check_val("flush_busy_after", 32'(busy_a), 32'd0);
    check_val("flush_stall_after", 32'(stall_a), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_a) seen++;
      @(negedge clk_sys);
      #1;
    end
    check_val("flush_no_done", 32'(seen), 32'd0);
    check_val("flush_result_kept", result_a, 32'd143);

    do_mul(0, 32'd3, 32'd5, 32'd15, 32, "mul3x5_after_flush");

    // Back-to-back: second MUL presented during DONE, accepted in the next IDLE
    @(negedge clk_sys);
    alu_ctrl = C_MUL; d1 = 32'd3; d2 = 32'd4; valid_a = 1'b1;
    ndone = 0; cyc1 = -1; cyc2 = -1; r1 = '0; r2 = '0;
    for (int c = 0; c < 2 * 32 + 10; c++) begin
      #1;
      if (done_a) begin
        if (ndone == 0) begin
          cyc1 = c; r1 = result_a; d1 = 32'd5; d2 = 32'd5;
        end else if (ndone == 1) begin
          cyc2 = c; r2 = result_a; valid_a = 1'b0;
        end
        ndone++;
      end
      @(negedge clk_sys);
    end
    valid_a = 1'b0;
    check_val("b2b_first_result", r1, 32'd12);
    check_val("b2b_second_result", r2, 32'd25);
    check_val("b2b_pulse_count", 32'(ndone), 32'd2);
    check_val("b2b_first_cycle", 32'(cyc1), 32'd33);
    check_val("b2b_gap", 32'(cyc2 - cyc1), 32'd34);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
